// File: rtl/rf_sequencer.sv
// rf_sequencer: four-state IDLE/READ/EXEC/WRITE register-file operation sequencer.
// Define RF_SEQ_SAT_EN for saturating add/sub; otherwise add/sub wrap modulo 256.
module rf_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [1:0] req_rs,
    input  logic [1:0] req_rt,
    input  logic [1:0] req_rd,
    output logic       rf_ren_wen,
    output logic [1:0] rf_readaddr1,
    output logic [1:0] rf_readaddr2,
    output logic [1:0] rf_writeaddr,
    output logic [7:0] acc,
    input  logic [7:0] rf_data1,
    input  logic [7:0] rf_data2,
    output logic       done,
    output logic [7:0] result,
    output logic       res_zero
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] WRITE = 2'd3;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [1:0] state;
    logic [1:0] op_q;
    logic [1:0] rs_q;
    logic [1:0] rt_q;
    logic [1:0] rd_q;
    logic [7:0] add_res;
    logic [7:0] sub_res;
    logic [7:0] alu;

`ifdef RF_SEQ_SAT_EN
    logic [8:0] sum;
    logic [8:0] diff;

    assign sum     = {1'b0, rf_data1} + {1'b0, rf_data2};
    assign diff    = {1'b0, rf_data1} - {1'b0, rf_data2};
    assign add_res = sum[8] ? 8'hFF : sum[7:0];
    assign sub_res = diff[8] ? 8'h00 : diff[7:0];
`else
    assign add_res = rf_data1 + rf_data2;
    assign sub_res = rf_data1 - rf_data2;
`endif

    always_comb begin
        alu = 8'h00;
        unique case (op_q)
            OP_ADD:  alu = add_res;
            OP_SUB:  alu = sub_res;
            OP_AND:  alu = rf_data1 & rf_data2;
            OP_OR:   alu = rf_data1 | rf_data2;
            default: alu = 8'h00;
        endcase
    end

    // Addresses come straight from the latched fields so they hold between ops.
    assign req_ready    = (state == IDLE);
    assign rf_readaddr1 = rs_q;
    assign rf_readaddr2 = rt_q;
    assign rf_writeaddr = rd_q;
    assign rf_ren_wen   = (state == WRITE) && (rd_q != 2'd0);
    assign res_zero     = (result == 8'h00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= 2'd0;
            rs_q   <= 2'd0;
            rt_q   <= 2'd0;
            rd_q   <= 2'd0;
            acc    <= 8'h00;
            result <= 8'h00;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q  <= req_op;
                        rs_q  <= req_rs;
                        rt_q  <= req_rt;
                        rd_q  <= req_rd;
                        state <= READ;
                    end
                end
                READ: begin
                    state <= EXEC;
                end
                EXEC: begin
                    acc   <= alu;
                    state <= WRITE;
                end
                WRITE: begin
                    result <= acc;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
